// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter and its priority picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width, kept at least 1 bit so a degenerate single-entry vector still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating-priority encoder: first set request at or after rr_ptr, wrapping.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_offset
            // rr_ptr + offset never reaches 2*NUM_REQ, so one conditional subtract wraps it.
            logic [IDX_W:0] sum;
            assign sum      = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                              IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid  = 1'b1;
                winner = cand[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with locked bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = idx_width(NUM_REQ),
    localparam int CNT_W      = cnt_width(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_REQ-1:0]            last_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_d_o,
    output logic [IDX_W-1:0]              owner_o,
    output logic                          busy_o
);

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [CNT_W-1:0]   beat_cnt_reg;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant;
    logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] d_mux;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req    (req_i),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Grant is zero-latency; reset and a full FIFO both force it off.
    always_comb begin
        grant = '0;
        if (!rst && !fifo_full_i) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant[pick_idx] = 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (req_i[owner_reg]) begin
                        grant[owner_reg] = 1'b1;
                    end
                end
                default: grant = '0;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data_mask
            assign masked_data[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[gi]}};
        end
    endgenerate

    always_comb begin
        d_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_mux = d_mux | masked_data[i];
        end
    end

    assign gnt_o        = grant;
    assign fifo_wr_en_o = |grant;
    assign fifo_d_o     = d_mux;
    assign busy_o       = (state_reg == ARB_BURST);
    assign owner_o      = owner_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (!fifo_full_i && pick_valid) begin
                        if (last_i[pick_idx] || (MAX_BURST == 1)) begin
                            rr_ptr_reg <= next_idx(pick_idx);
                        end else begin
                            state_reg    <= ARB_BURST;
                            owner_reg    <= pick_idx;
                            beat_cnt_reg <= CNT_W'(1);
                        end
                    end
                end
                ARB_BURST: begin
                    if (!req_i[owner_reg]) begin
                        // Owner dropped its request: release the lock without writing.
                        state_reg    <= ARB_IDLE;
                        rr_ptr_reg   <= next_idx(owner_reg);
                        beat_cnt_reg <= '0;
                    end else if (!fifo_full_i) begin
                        if (last_i[owner_reg] || (beat_cnt_reg == CNT_W'(MAX_BURST - 1))) begin
                            state_reg    <= ARB_IDLE;
                            rr_ptr_reg   <= next_idx(owner_reg);
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= ARB_IDLE;
                    beat_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round robin, burst cap, backpressure, withdrawal, reset.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  last_i;
    logic [3:0]  gnt_o;
    logic        fifo_full_i;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_d_o;
    logic [1:0]  owner_o;
    logic        busy_o;

    int vec_cnt     = 0;
    int miscompares = 0;
    int wr_total    = 0;
    int d1_words    = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .gnt_o        (gnt_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_d_o     (fifo_d_o),
        .owner_o      (owner_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] l, input logic f);
        req_i       = r;
        last_i      = l;
        fifo_full_i = f;
        #1;
    endtask

    // Records the write seen by the FIFO this cycle, then advances one clock.
    task automatic tick();
        if (fifo_wr_en_o === 1'b1) begin
            wr_total++;
            if (fifo_d_o === 8'hD1) d1_words++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_gnt(input string tag, input logic [3:0] g, input logic [7:0] d);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'(g));
        chk({tag, "_wen"}, 32'(fifo_wr_en_o), 32'(|g));
        chk({tag, "_d"}, 32'(fifo_d_o), 32'(d));
    endtask

    task automatic exp_state(input string tag, input logic b, input logic [1:0] o);
        chk({tag, "_busy"}, 32'(busy_o), 32'(b));
        chk({tag, "_owner"}, 32'(owner_o), 32'(o));
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] bz;
        data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        rst    = 1'b1;
        set_in(4'b1111, 4'b1111, 1'b0);

        // Reset held two cycles with all requests up.
        for (int i = 0; i < 2; i++) begin
            exp_gnt($sformatf("rst%0d", i), 4'b0000, 8'h00);
            tick();
        end
        exp_state("rst_regs", 1'b0, 2'd0);

        // Round robin, every beat single-word.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1111, 4'b1111, 1'b0);
            g = 4'b0001 << (i % 4);
            exp_gnt($sformatf("rr%0d", i), g, 8'hD0 + 8'(i % 4));
            chk($sformatf("rr%0d_busy", i), 32'(busy_o), 32'd0);
            tick();
        end

        // Burst cap: sole requester 0 gets 4 beats, then is re-granted a fresh burst.
        bz = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            set_in(4'b0001, 4'b0000, 1'b0);
            exp_gnt($sformatf("cap%0d", i), 4'b0001, 8'hD0);
            chk($sformatf("cap%0d_busy", i), 32'(busy_o), 32'(bz[i % 4]));
            tick();
        end
        set_in(4'b0000, 4'b0000, 1'b0);
        exp_gnt("cap_drop", 4'b0000, 8'h00);
        chk("cap_drop_busy", 32'(busy_o), 32'd1);
        tick();
        exp_state("cap_end", 1'b0, 2'd0);

        // Backpressure mid-burst: owner 2 keeps the lock while req1 waits.
        set_in(4'b0100, 4'b0000, 1'b0);
        exp_gnt("bp_b1", 4'b0100, 8'hD2);
        tick();
        exp_state("bp_lock", 1'b1, 2'd2);
        set_in(4'b0110, 4'b0000, 1'b0);
        exp_gnt("bp_b2", 4'b0100, 8'hD2);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(4'b0110, 4'b0000, 1'b1);
            exp_gnt($sformatf("bp_full%0d", i), 4'b0000, 8'h00);
            exp_state($sformatf("bp_full%0d", i), 1'b1, 2'd2);
            tick();
        end
        set_in(4'b0110, 4'b0000, 1'b0);
        exp_gnt("bp_b3", 4'b0100, 8'hD2);
        tick();
        exp_gnt("bp_b4", 4'b0100, 8'hD2);
        tick();
        chk("bp_done_busy", 32'(busy_o), 32'd0);
        set_in(4'b1010, 4'b1111, 1'b0);
        exp_gnt("bp_ptr3", 4'b1000, 8'hD3);
        tick();
        exp_gnt("bp_ptr0", 4'b0010, 8'hD1);
        tick();

        // Withdrawal by owner 3 releases the lock and wraps the pointer to 0.
        set_in(4'b1000, 4'b0000, 1'b0);
        exp_gnt("wd_b1", 4'b1000, 8'hD3);
        tick();
        exp_state("wd_lock", 1'b1, 2'd3);
        set_in(4'b0011, 4'b0000, 1'b0);
        exp_gnt("wd_drop", 4'b0000, 8'h00);
        tick();
        chk("wd_busy", 32'(busy_o), 32'd0);
        set_in(4'b0110, 4'b1111, 1'b0);
        exp_gnt("wd_next", 4'b0010, 8'hD1);
        tick();

        // Reset during beat 2 of owner 1 abandons the burst.
        d1_words = 0;
        set_in(4'b0010, 4'b0000, 1'b0);
        exp_gnt("mr_b1", 4'b0010, 8'hD1);
        tick();
        exp_state("mr_lock", 1'b1, 2'd1);
        rst = 1'b1;
        set_in(4'b0010, 4'b0000, 1'b0);
        exp_gnt("mr_rst", 4'b0000, 8'h00);
        tick();
        rst = 1'b0;
        set_in(4'b0000, 4'b0000, 1'b0);
        exp_state("mr_after", 1'b0, 2'd0);
        chk("mr_d1_words", 32'(d1_words), 32'd1);
        tick();
        set_in(4'b1111, 4'b1111, 1'b0);
        exp_gnt("mr_first", 4'b0001, 8'hD0);
        tick();
        chk("total_writes", 32'(wr_total), 32'd23);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
